// File: rtl/selector_parametros.sv
// Parameter selector: three debounced pushbuttons drive a two-mode
// (frequency / current) value selector with saturating up/down codes.

// One button lane: 2-flop synchronizer, stability counter, rising-edge pulse.
module selector_parametros_lane #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk_i,
  input  logic reset,
  input  logic raw_i,
  output logic press_o
);
  localparam int CW = $clog2(DEB_CYCLES);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          deb_q;
  logic          deb_d1_q;

  // Synchronize, qualify a new level after DEB_CYCLES differing samples,
  // and register a single pulse on each debounced rising edge.
  always_ff @(posedge clk_i) begin
    if (!reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      deb_q    <= 1'b0;
      deb_d1_q <= 1'b0;
      press_o  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      if (sync_q[1] != deb_q) begin
        if (cnt_q == CW'(DEB_CYCLES - 1)) begin
          deb_q <= sync_q[1];
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
      deb_d1_q <= deb_q;
      press_o  <= deb_q & ~deb_d1_q;
    end
  end
endmodule

// Top: per-button lanes feeding the mode FSM and value registers.
module selector_parametros #(
  parameter int DEB_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic       btn_modo_i,
  input  logic       btn_aum_i,
  input  logic       btn_dis_i,
  output logic       modo_o,
  output logic [2:0] valorf_o,
  output logic [3:0] valorC_o,
  output logic       cambio_o
);
  localparam int NUM_BTN = 3;

  typedef struct packed {
    logic modo;
    logic aum;
    logic dis;
  } press_t;

  // Encoding chosen so the state flop itself is the modo output.
  typedef enum logic {CORR = 1'b0, FREC = 1'b1} state_t;

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] press_vec;
  press_t             press;

  state_t     state_q, state_d;
  logic [2:0] valorf_d;
  logic [3:0] valorc_d;
  logic       cambio_d;

  assign raw   = {btn_modo_i, btn_aum_i, btn_dis_i};
  assign press = press_t'(press_vec);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
    selector_parametros_lane #(.DEB_CYCLES(DEB_CYCLES)) u_lane (
      .clk_i   (clk_i),
      .reset   (reset),
      .raw_i   (raw[i]),
      .press_o (press_vec[i])
    );
  end

  // State, value and change-pulse registers.
  always_ff @(posedge clk_i) begin
    if (!reset) begin
      state_q  <= FREC;
      valorf_o <= 3'd0;
      valorC_o <= 4'd1;
      cambio_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      valorf_o <= valorf_d;
      valorC_o <= valorc_d;
      cambio_o <= cambio_d;
    end
  end

  assign modo_o = state_q;

  // Next state and values: modo wins over aum/dis; aum+dis together cancel.
  always_comb begin
    state_d  = state_q;
    valorf_d = valorf_o;
    valorc_d = valorC_o;
    if (press.modo) begin
      state_d = (state_q == FREC) ? CORR : FREC;
    end else if (press.aum ^ press.dis) begin
      case (state_q)
        FREC: begin
          if (press.aum && valorf_o != 3'd7)      valorf_d = valorf_o + 3'd1;
          else if (press.dis && valorf_o != 3'd0) valorf_d = valorf_o - 3'd1;
        end
        default: begin
          if (press.aum && valorC_o < 4'd10)      valorc_d = valorC_o + 4'd1;
          else if (press.dis && valorC_o > 4'd1)  valorc_d = valorC_o - 4'd1;
        end
      endcase
    end
    // Out-of-range current codes are pulled back to the floor.
    if (valorC_o == 4'd0 || valorC_o > 4'd10) valorc_d = 4'd1;
    cambio_d = (state_d != state_q) || (valorf_d != valorf_o) || (valorc_d != valorC_o);
  end
endmodule

// File: tb/tb_selector_parametros.sv
// Directed bench for selector_parametros with DEB_CYCLES = 16.
module tb_selector_parametros;
  localparam int DEB = 16;

  logic       clk_i = 1'b0;
  logic       reset = 1'b0;
  logic       btn_modo_i = 1'b0, btn_aum_i = 1'b0, btn_dis_i = 1'b0;
  logic       modo_o;
  logic [2:0] valorf_o;
  logic [3:0] valorC_o;
  logic       cambio_o;

  int checks = 0;
  int failures = 0;
  int cambio_cnt = 0;

  selector_parametros #(.DEB_CYCLES(DEB)) dut (
    .clk_i      (clk_i),
    .reset      (reset),
    .btn_modo_i (btn_modo_i),
    .btn_aum_i  (btn_aum_i),
    .btn_dis_i  (btn_dis_i),
    .modo_o     (modo_o),
    .valorf_o   (valorf_o),
    .valorC_o   (valorC_o),
    .cambio_o   (cambio_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (cambio_o) cambio_cnt++;

  // Full press: hold {modo,aum,dis} long enough to qualify, then release and settle.
  task automatic press(input logic [2:0] b);
    @(negedge clk_i);
    {btn_modo_i, btn_aum_i, btn_dis_i} = b;
    repeat (DEB + 8) @(negedge clk_i);
    {btn_modo_i, btn_aum_i, btn_dis_i} = 3'b000;
    repeat (DEB + 8) @(negedge clk_i);
  endtask

  // Called right after the edge that first samples the button: returns the
  // edge index (1-based after that edge) at which valorf_o leaves 'base'.
  task automatic measure(input logic [2:0] base, output int found,
                         output logic cam_at, output logic cam_after);
    found = -1; cam_at = 1'b0; cam_after = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_i); #1;
      if (found == k - 1 && found > 0) cam_after = cambio_o;
      if (found < 0 && valorf_o != base) begin
        found = k;
        cam_at = cambio_o;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset = 1'b0;
    {btn_modo_i, btn_aum_i, btn_dis_i} = 3'b000;
    repeat (2) @(negedge clk_i);
    reset = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    @(negedge clk_i); reset = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++; if (modo_o !== 1'b1) begin failures++; $display("FAIL reset_modo got=%0b exp=1", modo_o); end
    checks++; if (valorf_o !== 3'd0) begin failures++; $display("FAIL reset_valorf got=%0d exp=0", valorf_o); end
    checks++; if (valorC_o !== 4'd1) begin failures++; $display("FAIL reset_valorC got=%0d exp=1", valorC_o); end
    checks++; if (cambio_o !== 1'b0) begin failures++; $display("FAIL reset_cambio got=%0b exp=0", cambio_o); end
    reset = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_latency();
    int f; logic ca, cb;
    @(negedge clk_i); btn_aum_i = 1'b1;
    @(posedge clk_i);
    measure(3'd0, f, ca, cb);
    checks++; if (f !== 19) begin failures++; $display("FAIL latency_edge got=%0d exp=19", f); end
    checks++; if (ca !== 1'b1) begin failures++; $display("FAIL latency_cambio_hi got=%0b exp=1", ca); end
    checks++; if (cb !== 1'b0) begin failures++; $display("FAIL latency_cambio_lo got=%0b exp=0", cb); end
    checks++; if (valorf_o !== 3'd1) begin failures++; $display("FAIL latency_valorf got=%0d exp=1", valorf_o); end
    checks++; if (modo_o !== 1'b1) begin failures++; $display("FAIL latency_modo got=%0b exp=1", modo_o); end
    btn_aum_i = 1'b0;
    repeat (DEB + 8) @(negedge clk_i);
  endtask

  task automatic test_bounce();
    int f; logic ca, cb; int c0;
    c0 = cambio_cnt;
    for (int s = 0; s < 12; s++) begin
      @(negedge clk_i); btn_aum_i = (s % 2 == 0);
      repeat (4) @(negedge clk_i);
    end
    checks++; if (valorf_o !== 3'd1) begin failures++; $display("FAIL bounce_no_change got=%0d exp=1", valorf_o); end
    @(negedge clk_i); btn_aum_i = 1'b1;
    @(posedge clk_i);
    measure(3'd1, f, ca, cb);
    checks++; if (f !== 19) begin failures++; $display("FAIL bounce_edge got=%0d exp=19", f); end
    checks++; if (valorf_o !== 3'd2) begin failures++; $display("FAIL bounce_valorf got=%0d exp=2", valorf_o); end
    btn_aum_i = 1'b0;
    repeat (DEB + 8) @(negedge clk_i);
    checks++; if (cambio_cnt - c0 !== 1) begin failures++; $display("FAIL bounce_cambio_count got=%0d exp=1", cambio_cnt - c0); end
  endtask

  task automatic test_saturation();
    int c0, late;
    do_reset();
    c0 = cambio_cnt;
    for (int i = 0; i < 7; i++) press(3'b010);
    checks++; if (cambio_cnt - c0 !== 7) begin failures++; $display("FAIL sat_f_steps got=%0d exp=7", cambio_cnt - c0); end
    c0 = cambio_cnt;
    press(3'b010); press(3'b010);
    late = cambio_cnt - c0;
    checks++; if (late !== 0) begin failures++; $display("FAIL sat_f_cambio got=%0d exp=0", late); end
    checks++; if (valorf_o !== 3'd7) begin failures++; $display("FAIL sat_valorf got=%0d exp=7", valorf_o); end
    press(3'b100);
    checks++; if (modo_o !== 1'b0) begin failures++; $display("FAIL sat_modo got=%0b exp=0", modo_o); end
    for (int i = 0; i < 9; i++) press(3'b010);
    c0 = cambio_cnt;
    for (int i = 0; i < 3; i++) press(3'b010);
    late = cambio_cnt - c0;
    checks++; if (late !== 0) begin failures++; $display("FAIL sat_c_cambio got=%0d exp=0", late); end
    checks++; if (valorC_o !== 4'd10) begin failures++; $display("FAIL sat_valorC got=%0d exp=10", valorC_o); end
    checks++; if (valorf_o !== 3'd7) begin failures++; $display("FAIL sat_valorf_kept got=%0d exp=7", valorf_o); end
  endtask

  task automatic test_floor();
    int c0;
    do_reset();
    press(3'b010);  // FREC: valorf 0 -> 1
    press(3'b100);  // -> CORR
    c0 = cambio_cnt;
    press(3'b001);  // dis at floor
    checks++; if (valorC_o !== 4'd1) begin failures++; $display("FAIL floor_valorC got=%0d exp=1", valorC_o); end
    checks++; if (cambio_cnt - c0 !== 0) begin failures++; $display("FAIL floor_cambio got=%0d exp=0", cambio_cnt - c0); end
    press(3'b100); press(3'b100);
    checks++; if (modo_o !== 1'b0) begin failures++; $display("FAIL floor_modo got=%0b exp=0", modo_o); end
    checks++; if (valorC_o !== 4'd1) begin failures++; $display("FAIL floor_valorC_kept got=%0d exp=1", valorC_o); end
    checks++; if (valorf_o !== 3'd1) begin failures++; $display("FAIL floor_valorf_kept got=%0d exp=1", valorf_o); end
  endtask

  task automatic test_simultaneous();
    int c0;
    press(3'b010);  // CORR: valorC 1 -> 2
    c0 = cambio_cnt;
    press(3'b011);
    checks++; if (valorC_o !== 4'd2) begin failures++; $display("FAIL simul_cancel_valorC got=%0d exp=2", valorC_o); end
    checks++; if (cambio_cnt - c0 !== 0) begin failures++; $display("FAIL simul_cancel_cambio got=%0d exp=0", cambio_cnt - c0); end
    c0 = cambio_cnt;
    press(3'b110);
    checks++; if (modo_o !== 1'b1) begin failures++; $display("FAIL simul_modo got=%0b exp=1", modo_o); end
    checks++; if (valorC_o !== 4'd2) begin failures++; $display("FAIL simul_modo_valorC got=%0d exp=2", valorC_o); end
    checks++; if (valorf_o !== 3'd1) begin failures++; $display("FAIL simul_modo_valorf got=%0d exp=1", valorf_o); end
    checks++; if (cambio_cnt - c0 !== 1) begin failures++; $display("FAIL simul_modo_cambio got=%0d exp=1", cambio_cnt - c0); end
  endtask

  task automatic test_reset_mid_press();
    int f; logic ca, cb;
    @(negedge clk_i); btn_aum_i = 1'b1;
    @(posedge clk_i);
    repeat (11) @(posedge clk_i);
    @(negedge clk_i); reset = 1'b0;
    @(negedge clk_i); reset = 1'b1;
    checks++; if (modo_o !== 1'b1) begin failures++; $display("FAIL midrst_modo got=%0b exp=1", modo_o); end
    checks++; if (valorf_o !== 3'd0) begin failures++; $display("FAIL midrst_valorf got=%0d exp=0", valorf_o); end
    checks++; if (valorC_o !== 4'd1) begin failures++; $display("FAIL midrst_valorC got=%0d exp=1", valorC_o); end
    checks++; if (cambio_o !== 1'b0) begin failures++; $display("FAIL midrst_cambio got=%0b exp=0", cambio_o); end
    @(posedge clk_i);
    measure(3'd0, f, ca, cb);
    checks++; if (f !== 19) begin failures++; $display("FAIL midrst_edge got=%0d exp=19", f); end
    checks++; if (valorf_o !== 3'd1) begin failures++; $display("FAIL midrst_single_inc got=%0d exp=1", valorf_o); end
    btn_aum_i = 1'b0;
    repeat (DEB + 8) @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_saturation();
    test_floor();
    test_simultaneous();
    test_reset_mid_press();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
